sync_fifo: RTL

//  Single-clock synchronous FIFO; the design-side responder for the fifo_interface bench
//  (driver pushes wr_en/rd_en/wr_data, monitor samples full/empty/almst_*/rd_data).

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 51 +++++
 rtl/sync_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and helpers for the sync_fifo block.
//               DEFAULT_DATA_W / DEFAULT_DEPTH give the stock configuration;
//               ptr_w() returns the address width for a given depth.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 128;
    localparam int DEFAULT_DEPTH  = 16;

    // Address width needed to index a memory of 'depth' entries.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x DATA_W storage with one synchronous write port and
//               one synchronous read port. The read word is registered and
//               holds its value on cycles with re=0. Only the read register
//               is reset; the array contents are left untouched.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               we/waddr/wdata    - write port
//               re/raddr/rdata    - read port (rdata valid the cycle after re)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array has no reset so it can map onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data and programmable
//               almost-full / almost-empty thresholds. Occupancy is tracked
//               by an explicit counter; full/empty never come from pointer
//               comparison.
// Build macro : FIFO_ERR_FLAGS_EN - when defined, adds sticky overflow and
//               underflow outputs (cleared only by reset).
// Ports       : clk, reset                - clock, sync active-high reset
//               wr_en, wr_data            - push request and data
//               rd_en, rd_data            - pop request, popped word (+1 cycle)
//               full, empty               - count == DEPTH / count == 0
//               almst_full, almst_empty   - count >= DEPTH-AF_MARGIN /
//                                           count <= AE_MARGIN
//               overflow, underflow       - FIFO_ERR_FLAGS_EN only
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almst_full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              almst_empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af_level = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] c_ae_level = CNT_W'(AE_MARGIN);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almst_full;
    logic             r_almst_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Accept decisions use the flags registered at the previous edge, so a
    // full FIFO still takes a pop and an empty one still takes a push.
    assign w_push = wr_en & ~r_full;
    assign w_pop  = rd_en & ~r_empty;

    assign w_count_nxt = r_count
                       + {{(CNT_W-1){1'b0}}, w_push}
                       - {{(CNT_W-1){1'b0}}, w_pop};

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count <= w_count_nxt;
        end
    end

    // Flags are registered from the next count so they line up with the
    // pointer/count update at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almst_full  <= 1'b0;
            r_almst_empty <= 1'b1;
        end else begin
            r_full        <= (w_count_nxt == c_depth);
            r_empty       <= (w_count_nxt == '0);
            r_almst_full  <= (w_count_nxt >= c_af_level);
            r_almst_empty <= (w_count_nxt <= c_ae_level);
        end
    end

    assign full        = r_full;
    assign empty       = r_empty;
    assign almst_full  = r_almst_full;
    assign almst_empty = r_almst_empty;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & r_full)  r_overflow  <= 1'b1;
            if (rd_en & r_empty) r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    // With 0 < count < DEPTH the read and write addresses differ, so a
    // same-cycle push and pop never touch the same entry.
    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .re    (w_pop),
        .raddr (r_rd_ptr),
        .rdata (rd_data)
    );

endmodule : sync_fifo
`default_nettype wire
